// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
//   fetch_state_e : controller FSM state
//   fetch_entry_t : {pc, inst} payload carried by the fetch FIFOs
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries with synchronous clear.
//   clk, rst_n (sync, active-low), clr : clock / reset / flush
//   push, wdata                        : write side
//   pop, rdata                         : read side (rdata is zero when empty)
//   full, empty, count                 : status
// A pop and a push may share a cycle even when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt;
  logic           do_push;
  logic           do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && !clr && (!full || do_pop);
  assign count   = cnt;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller closing the loop around the pc register.
//   clk, rst_n (sync, active-low)
//   pc_out -> pc_in        : current / next PC (+4, redirect, hold, reset vector)
//   imem_req/addr/gnt      : in-order fetch requests
//   imem_rvalid/rdata      : in-order responses
//   redirect_valid/pc      : branch/jump redirect, flushes buffered and in-flight fetches
//   inst_valid/ready/inst/inst_pc : decoded-side valid/ready instruction stream
// Optional feature macro FETCH_ALIGN_CHECK_EN adds output fetch_err, a sticky flag
// for misaligned redirect targets that blocks further requests until reset.
// Without the macro the low two target bits are forced to zero.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_out,
  output logic [31:0] pc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_err
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_e  state;
  fetch_state_e  state_nxt;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] discard_nxt;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] out_after;
  logic [CW-1:0] ib_count;
  logic          aq_full;
  logic          aq_empty;
  logic          ib_full;
  logic          ib_empty;
  fetch_entry_t  aq_wdata;
  fetch_entry_t  aq_rdata;
  fetch_entry_t  ib_wdata;
  fetch_entry_t  ib_rdata;
  logic          grant;
  logic          rsp;
  logic          redir;
  logic          ib_push;
  logic          ib_pop;
  logic          credit;
  logic          err_block;
  logic [31:0]   redir_tgt;

  assign imem_addr = pc_out;
  assign grant     = imem_req && imem_gnt;
  // Responses with no matching side-queue entry (pre-reset traffic) are ignored.
  assign rsp       = imem_rvalid && !aq_empty;
  assign redir     = redirect_valid && (state != ST_BOOT);
  assign ib_pop    = !ib_empty && inst_ready;
  // Outstanding count once this cycle's grant and response have landed.
  assign out_after = out_cnt + CW'(grant) - CW'(rsp);
  // Occupancy excludes the entry leaving this cycle, so a steady stream needs no bubble.
  assign credit    = (({1'b0, out_cnt} + {1'b0, ib_count} - SW'(ib_pop)) < SW'(DEPTH));

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_tgt = redirect_pc;
  assign err_block = fetch_err;

  // Sticky misaligned-redirect flag.
  always_ff @(posedge clk) begin
    if (!rst_n)                                  fetch_err <= 1'b0;
    else if (redir && (redirect_pc[1:0] != 2'b00)) fetch_err <= 1'b1;
  end
`else
  assign redir_tgt = redirect_pc & ~32'(INST_BYTES - 1);
  assign err_block = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      discard_cnt <= '0;
    end else begin
      state       <= state_nxt;
      discard_cnt <= discard_nxt;
    end
  end

  // Next state and discard count.
  always_comb begin
    state_nxt   = state;
    discard_nxt = discard_cnt;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN, ST_FLUSH: begin
        if (redir) begin
          discard_nxt = out_after;
          state_nxt   = (out_after != '0) ? ST_FLUSH : ST_RUN;
        end else if (state == ST_FLUSH && rsp) begin
          discard_nxt = (discard_cnt != '0) ? discard_cnt - CW'(1) : '0;
          if (discard_cnt <= CW'(1)) state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Request, next PC and buffer push.
  always_comb begin
    imem_req = 1'b0;
    pc_in    = pc_out;
    ib_push  = 1'b0;
    if (state == ST_RUN && !redirect_valid && credit && !aq_full && !err_block)
      imem_req = 1'b1;
    if (state == ST_BOOT)             pc_in = RESET_VEC;
    else if (redirect_valid)          pc_in = redir_tgt;
    else if (imem_req && imem_gnt)    pc_in = pc_out + 32'(INST_BYTES);
    if (rsp && state == ST_RUN && !redirect_valid && (!ib_full || ib_pop))
      ib_push = 1'b1;
  end

  // Response data paired with the address popped from the side queue.
  always_comb begin
    aq_wdata      = '0;
    aq_wdata.pc   = pc_out;
    ib_wdata      = aq_rdata;
    ib_wdata.inst = imem_rdata;
  end

  // Address side queue; its occupancy is the outstanding-request count.
  fetch_fifo #(.DEPTH(DEPTH)) u_addr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .push  (grant),
    .pop   (rsp),
    .wdata (aq_wdata),
    .rdata (aq_rdata),
    .full  (aq_full),
    .empty (aq_empty),
    .count (out_cnt)
  );

  // Instruction buffer toward decode.
  fetch_fifo #(.DEPTH(DEPTH)) u_inst_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (redir),
    .push  (ib_push),
    .pop   (ib_pop),
    .wdata (ib_wdata),
    .rdata (ib_rdata),
    .full  (ib_full),
    .empty (ib_empty),
    .count (ib_count)
  );

  assign inst_valid = !ib_empty;
  assign inst       = ib_rdata.inst;
  assign inst_pc    = ib_rdata.pc;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that closes the loop around the `pc` register. It reads the current PC (`pc_out`), issues in-order requests to instruction memory, and computes the next PC (`pc_in`): sequential +4, a redirect target, or hold. Returned instructions are buffered in a small FIFO and presented to decode with a valid/ready handshake. Redirects (branch/jump) flush buffered and in-flight fetches.

## Interface
- `DEPTH`, 2: instruction buffer entries; also the maximum number of outstanding requests plus buffered entries (power of two, ≥2).
- `RESET_VEC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `pc_out` in 32: current PC from the `pc` register.
- `pc_in` out 32: next PC to the `pc` register.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address (= `pc_out`).
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid. Responses are in order, no earlier than the cycle after grant.
- `imem_rdata` in 32: response instruction.
- `redirect_valid` in 1: redirect request from execute.
- `redirect_pc` in 32: redirect target.
- `inst_valid` out 1: buffered instruction available.
- `inst_ready` in 1: decode accepts the instruction.
- `inst` out 32: instruction at the FIFO head.
- `inst_pc` out 32: address of `inst`.

## Operation
- FSM states:
  - BOOT: first cycle after reset. Drives `pc_in`=`RESET_VEC`. No request. Goes to RUN.
  - RUN: normal fetch.
  - FLUSH: draining discarded responses after a redirect.
- `pc_in` priority:
  1. BOOT → `RESET_VEC`.
  2. `redirect_valid` → `redirect_pc`.
  3. `imem_req && imem_gnt` → `pc_out + 4`, wrapping modulo 2^32.
  4. Otherwise → `pc_out` (hold).
- `imem_req` = (state==RUN) && !`redirect_valid` && (outstanding + occupancy < `DEPTH`).
- `imem_addr` = `pc_out`. Address is stable while req is high and gnt is low.
- Outstanding counter: +1 on grant, −1 on `imem_rvalid`; both in one cycle → unchanged.
- Each accepted request pushes its address into a side queue. On `imem_rvalid`, the response is pushed into the FIFO with its PC, unless it is being discarded.
- Redirect, when `redirect_valid`=1 in any state except BOOT:
  - FIFO is emptied; a pop in the same cycle is ignored.
  - discard count ← outstanding after this cycle's grant/response updates.
  - Next state: FLUSH if the count is >0, else RUN.
- FLUSH: each `imem_rvalid` decrements the discard count and its data is dropped. At zero → RUN. A new redirect in FLUSH reloads the count as above.
- Output: `inst_valid` = FIFO not empty. Pop on `inst_valid && inst_ready`. Push and pop may happen in the same cycle when the FIFO is full; the counter guarantees no overflow.
- Reset (`rst_n`=0 at a clock edge), including mid-fetch:
  - state ← BOOT; FIFO, counters and side queue ← 0.
  - `imem_req`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `pc_in`=`RESET_VEC`.
  - Responses to requests granted before reset are ignored; the memory is also reset.

## Timing
- Cycle 0 = first edge with `rst_n`=1.
- Boot: `pc_out`=`RESET_VEC` at cycle 1; first `imem_req` at cycle 1.
- Fetch latency: with 1-cycle memory latency, grant at cycle N gives response at N+1 and `inst_valid` at N+2 (FIFO registered).
- Throughput: one instruction per cycle with `DEPTH`≥2 and zero-wait memory.
- Redirect at cycle N: `pc_out`=`redirect_pc` at N+1. First request of the new stream is at N+1 if nothing is outstanding, otherwise the cycle after the last discarded response.

## Configuration
- `FETCH_ALIGN_CHECK_EN`:
  - Defined: adds output `fetch_err` (1 bit, reset 0). A redirect with `redirect_pc[1:0]`≠0 sets `fetch_err`, sticky until reset, and the controller stays in FLUSH/idle issuing no requests.
  - Undefined: no port; `redirect_pc[1:0]` is forced to 0.

## Structure
- Package `fetch_pkg`: FSM state enum `fetch_state_e`, constant `INST_BYTES`=4, default `RESET_VEC`.
- Sub-module `fetch_fifo`: parameterised synchronous FIFO of {pc, inst}, with push/pop/full/empty/count. It is instantiated for the instruction buffer and for the address side queue.

## Test plan
- Reset release, `imem_gnt`=1, 1-cycle memory returning addr^32'hA5A5_A5A5, `inst_ready`=1 → `inst_pc` sequence 0,4,8,C… one per cycle from cycle 3.
- `inst_ready`=0 for 10 cycles → exactly `DEPTH` requests issued, `imem_req` drops, no data lost; on release the order is preserved.
- Redirect to 32'h100 while 2 requests are outstanding → both responses discarded, FIFO cleared, next `inst_pc`=32'h100.
- `imem_gnt` low for 3 cycles → `imem_addr` stable and `pc_in`=`pc_out` until grant.
- `pc_out`=32'hFFFF_FFFC granted → `pc_in`=0 (wrap).
- With `FETCH_ALIGN_CHECK_EN`, redirect to 32'h102 → `fetch_err`=1 next cycle, no further `imem_req` until reset.
